z80_ir_regfile: RTL and testbench
=================================

Name: z80_ir_regfile

Overview:
- Sequential owner of the Z80 I (interrupt vector) and R (refresh) registers for the core.
- Implements the four special transfers: LD A,I; LD A,R; LD I,A; LD R,A.
- Generalises the single LD A,R behaviour with:
  - a parametrised R auto-increment width;
  - optional modelling of the NMOS interrupt-acceptance P/V quirk;
  - a two-state execute FSM;
  - a refresh-address output.

Parameters:
R_BITS, 7, number of low R bits that auto-increment (1..8); upper bits are held.
PV_QUIRK, 1, 1 = P/V forced to 0 if an interrupt is accepted during LD A,I/LD A,R.
RESET_I, 8'h00, reset value of I.
RESET_R, 8'h00, reset value of R.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
m1_fetch  in  1  one-cycle pulse per opcode-fetch M1, including prefix bytes
refresh_en  in  1  high during T3/T4 of M1
op_start  in  1  one-cycle request to execute op_sel
op_sel  in  2  0=LD A,I  1=LD A,R  2=LD I,A  3=LD R,A
a_in  in  8  current A
f_in  in  8  current F
iff2  in  1  current IFF2
int_accept  in  1  interrupt acknowledged this cycle
busy  out  1  op in flight
res_valid  out  1  one-cycle pulse: a_out/f_out valid, I/R write done
a_out  out  8  resulting A
f_out  out  8  resulting F
reg_i  out  8  current I
reg_r  out  8  current R
refresh_addr  out  16  {I,R} latched for refresh
refresh_valid  out  1  refresh_addr valid

Behaviour:
- Reset (async, reset_n=0):
  - I=RESET_I, R=RESET_R.
  - FSM=IDLE; busy, res_valid and refresh_valid =0.
  - a_out, f_out and refresh_addr =0.
- R increment:
  - On an m1_fetch edge, R[R_BITS-1:0] += 1, modulo 2^R_BITS; R[7:R_BITS] is unchanged.
  - With R_BITS=8 the full 8 bits wrap.
- FSM IDLE -> EXEC -> IDLE:
  - In IDLE, op_start latches op_sel, a_in and f_in, and latches the source (I or R as registered this cycle, before any same-edge increment). It also latches iff2 and clears the quirk flag. Next state is EXEC; busy=1.
  - EXEC lasts one cycle. At the EXEC->IDLE edge:
    - res_valid=1 for exactly one cycle;
    - a_out and f_out are registered;
    - any I/R write is committed.
  - Latency is 2 clocks from op_start to res_valid.
- Quirk flag: set if int_accept=1 in the op_start cycle or in the EXEC cycle. Ignored when PV_QUIRK=0.
- LD A,I / LD A,R results:
  - a_out=src.
  - f_out = (f_in & 0x29) | S=src[7] | Z=(src==0) | PV=(iff2_latched & ~quirk).
  - H=0, N=0.
- LD I,A / LD R,A results:
  - a_out=a_in and f_out=f_in, unchanged.
  - Target register receives all 8 bits of a_in.
- Simultaneous events:
  - An LD R,A commit on the same edge as m1_fetch: the write wins, R=a_in, and that increment is lost.
  - An LD A,R with m1_fetch in the op_start cycle reads the pre-increment value.
- op_start while busy is ignored; no queueing.
- Refresh: when refresh_en=1, refresh_addr <= {I,R} and refresh_valid <= 1; otherwise refresh_valid <= 0.
- Reset mid-EXEC aborts the op: no write, no res_valid.

Decomposition:
- Package z80_ir_pkg:
  - op_sel enum (OP_LD_A_I, OP_LD_A_R, OP_LD_I_A, OP_LD_R_A);
  - FSM state enum (ST_IDLE, ST_EXEC);
  - flag mask constant PRESERVE_MASK=8'h29.
  - Flag bit positions come from the shared FLAG_* definitions.
- One sub-module: z80_r_counter, which handles the masked increment, the load with load-over-increment priority, and reset.

Test Plan:
1. Reset pulse -> reg_i=00, reg_r=00, busy=0, res_valid=0, refresh_valid=0.
2. R=7F, R_BITS=7, one m1_fetch -> R=00; then R=FF, one m1_fetch -> R=80.
3. LD A,R with R=80, iff2=1, f_in=29 -> res_valid 2 clocks later, a_out=80, f_out=AD.
4. LD A,I with I=00, iff2=1, f_in=00, int_accept in EXEC, PV_QUIRK=1 -> f_out=40. Same with PV_QUIRK=0 -> f_out=44.
5. LD R,A with a_in=55 and m1_fetch on the commit edge -> reg_r=55, not 56. Then refresh_en with I=12 -> refresh_addr=1255, refresh_valid=1.
6. op_start while busy -> ignored, one res_valid only. reset_n low during EXEC -> no res_valid, I/R return to reset values.

Source files
------------

// File: rtl/z80_ir_regfile_pkg.sv
// Shared types and constants for the Z80 I/R register block.
// Holds the special-transfer opcodes, FSM states, flag bit positions and the flag helper.
package z80_ir_pkg;

  typedef enum logic [1:0] {
    OP_LD_A_I = 2'd0,
    OP_LD_A_R = 2'd1,
    OP_LD_I_A = 2'd2,
    OP_LD_R_A = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  localparam int FLAG_C  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_PV = 2;
  localparam int FLAG_X  = 3;
  localparam int FLAG_H  = 4;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_S  = 7;

  // C and the undocumented X/Y copies pass through; H and N are cleared.
  localparam logic [7:0] PRESERVE_MASK = 8'h29;

  function automatic logic [7:0] ld_air_flags(input logic [7:0] src, input logic [7:0] f,
                                               input logic pv);
    logic [7:0] res;
    res          = f & PRESERVE_MASK;
    res[FLAG_S]  = src[7];
    res[FLAG_Z]  = (src == 8'h00);
    res[FLAG_PV] = pv;
    return res;
  endfunction

endpackage

// File: rtl/z80_ir_regfile_r_counter.sv
// Refresh register R: low R_BITS bits count M1 fetches, upper bits hold.
// A load on the same edge as an increment wins and the increment is dropped.
module z80_r_counter #(
  parameter int         R_BITS  = 7,
  parameter logic [7:0] RESET_R = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] r
);

  localparam logic [8:0] ONE_SHIFTED = 9'd1 << R_BITS;
  localparam logic [7:0] INC_MASK    = 8'(ONE_SHIFTED - 9'd1);

  logic [7:0] r_inc;

  assign r_inc = (r & ~INC_MASK) | ((r + 8'd1) & INC_MASK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r <= RESET_R;
    end else if (load) begin
      r <= load_val;
    end else if (inc) begin
      r <= r_inc;
    end
  end

endmodule

// File: rtl/z80_ir_regfile.sv
// I/R register owner: executes LD A,I / LD A,R / LD I,A / LD R,A with a two-cycle
// IDLE->EXEC handshake and publishes {I,R} as the refresh address.
module z80_ir_regfile
  import z80_ir_pkg::*;
#(
  parameter int         R_BITS   = 7,
  parameter bit         PV_QUIRK = 1'b1,
  parameter logic [7:0] RESET_I  = 8'h00,
  parameter logic [7:0] RESET_R  = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m1_fetch,
  input  logic        refresh_en,
  input  logic        op_start,
  input  logic [1:0]  op_sel,
  input  logic [7:0]  a_in,
  input  logic [7:0]  f_in,
  input  logic        iff2,
  input  logic        int_accept,
  output logic        busy,
  output logic        res_valid,
  output logic [7:0]  a_out,
  output logic [7:0]  f_out,
  output logic [7:0]  reg_i,
  output logic [7:0]  reg_r,
  output logic [15:0] refresh_addr,
  output logic        refresh_valid
);

  state_e     state, state_nx;
  op_e        op_q;
  logic [7:0] a_q, f_q, src_q;
  logic       iff2_q, quirk_q;
  logic       accept, commit, quirk_eff;
  logic [7:0] a_res, f_res;

  assign accept    = (state == ST_IDLE) && op_start;
  assign commit    = (state == ST_EXEC);
  assign busy      = (state == ST_EXEC);
  // An interrupt taken in either cycle of the op corrupts P/V on NMOS parts.
  assign quirk_eff = PV_QUIRK && (quirk_q || int_accept);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (op_start) state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    a_res = a_q;
    f_res = f_q;
    if (op_q == OP_LD_A_I || op_q == OP_LD_A_R) begin
      a_res = src_q;
      f_res = ld_air_flags(src_q, f_q, iff2_q & ~quirk_eff);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= OP_LD_A_I;
      a_q     <= 8'h00;
      f_q     <= 8'h00;
      src_q   <= 8'h00;
      iff2_q  <= 1'b0;
      quirk_q <= 1'b0;
    end else if (accept) begin
      op_q    <= op_e'(op_sel);
      a_q     <= a_in;
      f_q     <= f_in;
      src_q   <= (op_e'(op_sel) == OP_LD_A_I) ? reg_i : reg_r;
      iff2_q  <= iff2;
      quirk_q <= int_accept;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      a_out     <= 8'h00;
      f_out     <= 8'h00;
      reg_i     <= RESET_I;
    end else begin
      res_valid <= commit;
      if (commit) begin
        a_out <= a_res;
        f_out <= f_res;
        if (op_q == OP_LD_I_A) reg_i <= a_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_valid <= 1'b0;
      refresh_addr  <= 16'h0000;
    end else begin
      refresh_valid <= refresh_en;
      if (refresh_en) refresh_addr <= {reg_i, reg_r};
    end
  end

  z80_r_counter #(
    .R_BITS  (R_BITS),
    .RESET_R (RESET_R)
  ) u_r_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (m1_fetch),
    .load     (commit && (op_q == OP_LD_R_A)),
    .load_val (a_q),
    .r        (reg_r)
  );

endmodule

// File: tb/tb_z80_ir_regfile.sv
// Scoreboard bench: two instances (R_BITS=7/quirk on, R_BITS=8/quirk off) share stimulus
// and are compared against an arithmetic reference model of the I/R transfer rules.
module tb_z80_ir_regfile;

  logic        clk = 1'b0;
  logic        reset_n, m1_fetch, refresh_en, op_start, iff2, int_accept;
  logic [1:0]  op_sel;
  logic [7:0]  a_in, f_in;
  logic        busy[2], res_valid[2], refresh_valid[2];
  logic [7:0]  a_out[2], f_out[2], reg_i[2], reg_r[2];
  logic [15:0] refresh_addr[2];

  always #5 clk = ~clk;

  z80_ir_regfile #(.R_BITS(7), .PV_QUIRK(1'b1), .RESET_I(8'h00), .RESET_R(8'h00)) u0 (
    .clk(clk), .reset_n(reset_n), .m1_fetch(m1_fetch), .refresh_en(refresh_en),
    .op_start(op_start), .op_sel(op_sel), .a_in(a_in), .f_in(f_in), .iff2(iff2),
    .int_accept(int_accept), .busy(busy[0]), .res_valid(res_valid[0]), .a_out(a_out[0]),
    .f_out(f_out[0]), .reg_i(reg_i[0]), .reg_r(reg_r[0]), .refresh_addr(refresh_addr[0]),
    .refresh_valid(refresh_valid[0]));

  z80_ir_regfile #(.R_BITS(8), .PV_QUIRK(1'b0), .RESET_I(8'h00), .RESET_R(8'h00)) u1 (
    .clk(clk), .reset_n(reset_n), .m1_fetch(m1_fetch), .refresh_en(refresh_en),
    .op_start(op_start), .op_sel(op_sel), .a_in(a_in), .f_in(f_in), .iff2(iff2),
    .int_accept(int_accept), .busy(busy[1]), .res_valid(res_valid[1]), .a_out(a_out[1]),
    .f_out(f_out[1]), .reg_i(reg_i[1]), .reg_r(reg_r[1]), .refresh_addr(refresh_addr[1]),
    .refresh_valid(refresh_valid[1]));

  typedef struct packed {
    logic [31:0] due;
    logic [7:0]  a0, a1, f0, f1;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  bit          mon_en = 1'b0;
  int          m_cyc = 0;
  logic [7:0]  m_i[2], m_r[2];
  logic [15:0] m_ra[2];
  bit          m_rv, m_busy;
  int          p_op;
  logic [7:0]  p_a, p_f, p_src[2];
  bit          p_iff2, p_q;
  int          rb[2] = '{7, 8};
  bit          pq[2] = '{1'b1, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] r_next(input logic [7:0] r, input int bits);
    int m, lo;
    m  = 1 << bits;
    lo = int'(r) % m;
    return 8'((int'(r) - lo) + (lo + 1) % m);
  endfunction

  function automatic logic [7:0] air_flags(input logic [7:0] src, input logic [7:0] f,
                                           input bit pv);
    return (f & 8'h29) | ((src >= 8'd128) ? 8'h80 : 8'h00) | ((src == 8'd0) ? 8'h40 : 8'h00)
           | (pv ? 8'h04 : 8'h00);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_i[k] = 8'h00; m_r[k] = 8'h00; m_ra[k] = 16'h0000;
    end
    m_rv = 1'b0; m_busy = 1'b0;
  endtask

  task automatic tick();
    logic [7:0] oi[2], orr[2];
    exp_t e;
    bit quirk;
    @(posedge clk);
    m_cyc++;
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin oi[k] = m_i[k]; orr[k] = m_r[k]; end
      m_rv = refresh_en;
      if (refresh_en) for (int k = 0; k < 2; k++) m_ra[k] = {oi[k], orr[k]};
      if (m_busy) begin
        e.due = 32'(m_cyc);
        for (int k = 0; k < 2; k++) begin
          logic [7:0] ea, ef;
          quirk = pq[k] && (p_q || int_accept);
          if (p_op < 2) begin ea = p_src[k]; ef = air_flags(p_src[k], p_f, p_iff2 && !quirk); end
          else begin ea = p_a; ef = p_f; end
          if (k == 0) begin e.a0 = ea; e.f0 = ef; end else begin e.a1 = ea; e.f1 = ef; end
          if (p_op == 2) m_i[k] = p_a;
          if (p_op == 3) m_r[k] = p_a;
          else if (m1_fetch) m_r[k] = r_next(orr[k], rb[k]);
        end
        sb.push_back(e);
        m_busy = 1'b0;
      end else begin
        for (int k = 0; k < 2; k++) if (m1_fetch) m_r[k] = r_next(orr[k], rb[k]);
        if (op_start) begin
          p_op = int'(op_sel); p_a = a_in; p_f = f_in; p_iff2 = iff2; p_q = int_accept;
          for (int k = 0; k < 2; k++) p_src[k] = (op_sel == 2'd0) ? oi[k] : orr[k];
          m_busy = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input bit m1, input bit ren, input bit ost, input logic [1:0] sel,
                       input logic [7:0] a, input logic [7:0] f, input bit i2, input bit ia);
    m1_fetch = m1; refresh_en = ren; op_start = ost; op_sel = sel;
    a_in = a; f_in = f; iff2 = i2; int_accept = ia;
    tick();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_reg_i", 32'(reg_i[k]), 32'h00);
      chk("rst_reg_r", 32'(reg_r[k]), 32'h00);
      chk("rst_busy", 32'(busy[k]), 32'h0);
      chk("rst_res_valid", 32'(res_valid[k]), 32'h0);
      chk("rst_refresh_valid", 32'(refresh_valid[k]), 32'h0);
    end
    idle(1);
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit ev;
      ev = (sb.size() > 0) && (sb[0].due == 32'(m_cyc));
      for (int k = 0; k < 2; k++) begin
        chk("res_valid", 32'(res_valid[k]), 32'(ev));
        chk("busy", 32'(busy[k]), 32'(m_busy));
        chk("reg_i", 32'(reg_i[k]), 32'(m_i[k]));
        chk("reg_r", 32'(reg_r[k]), 32'(m_r[k]));
        chk("refresh_valid", 32'(refresh_valid[k]), 32'(m_rv));
        chk("refresh_addr", 32'(refresh_addr[k]), 32'(m_ra[k]));
        if (ev) begin
          chk("a_out", 32'(a_out[k]), 32'((k == 0) ? sb[0].a0 : sb[0].a1));
          chk("f_out", 32'(f_out[k]), 32'((k == 0) ? sb[0].f0 : sb[0].f1));
        end
      end
      if (ev) void'(sb.pop_front());
      else if (sb.size() > 0 && sb[0].due < 32'(m_cyc)) begin
        chk("res_missed", 32'(sb[0].due), 32'(m_cyc));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    m1_fetch = 0; refresh_en = 0; op_start = 0; op_sel = 2'd0;
    a_in = 8'h00; f_in = 8'h00; iff2 = 0; int_accept = 0;
    model_reset();
    #2;
    mon_en = 1'b1;
    do_reset();
    idle(2);

    // R increment wrap: 7F -> 00 (7-bit), 7F -> 80 (8-bit); FF -> 80 / 00
    drive(0, 0, 1, 2'd3, 8'h7F, 8'h00, 0, 0); idle(1);
    drive(1, 0, 0, 2'd0, 8'h00, 8'h00, 0, 0);
    chk("r_wrap7_a", 32'(reg_r[0]), 32'h00);
    chk("r_wrap8_a", 32'(reg_r[1]), 32'h80);
    drive(0, 0, 1, 2'd3, 8'hFF, 8'h00, 0, 0); idle(1);
    drive(1, 0, 0, 2'd0, 8'h00, 8'h00, 0, 0);
    chk("r_wrap7_b", 32'(reg_r[0]), 32'h80);
    chk("r_wrap8_b", 32'(reg_r[1]), 32'h00);

    // LD A,R with R=80, iff2=1, f_in=29
    drive(0, 0, 1, 2'd3, 8'h80, 8'h00, 0, 0); idle(1);
    drive(0, 0, 1, 2'd1, 8'h00, 8'h29, 1, 0);
    chk("ldar_latency", 32'(res_valid[0]), 32'h0);
    idle(1);
    chk("ldar_valid", 32'(res_valid[0]), 32'h1);
    chk("ldar_a", 32'(a_out[0]), 32'h80);
    chk("ldar_f", 32'(f_out[0]), 32'hAD);
    idle(1);

    // LD A,I with I=00 and interrupt accepted during EXEC
    drive(0, 0, 1, 2'd0, 8'h00, 8'h00, 1, 0);
    drive(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 1);
    chk("ldai_quirk_f", 32'(f_out[0]), 32'h40);
    chk("ldai_noquirk_f", 32'(f_out[1]), 32'h44);
    idle(1);

    // LD R,A with m1 on the commit edge, then refresh with I=12
    drive(0, 0, 1, 2'd3, 8'h55, 8'h00, 0, 0);
    drive(1, 0, 0, 2'd0, 8'h00, 8'h00, 0, 0);
    chk("ldra_over_inc", 32'(reg_r[0]), 32'h55);
    drive(0, 0, 1, 2'd2, 8'h12, 8'h00, 0, 0); idle(1);
    drive(0, 1, 0, 2'd0, 8'h00, 8'h00, 0, 0);
    chk("refresh_addr_1255", 32'(refresh_addr[0]), 32'h1255);
    chk("refresh_valid_1", 32'(refresh_valid[0]), 32'h1);
    idle(1);

    // op_start while busy is dropped; reset mid-EXEC aborts the write
    drive(0, 0, 1, 2'd0, 8'h00, 8'h00, 0, 0);
    drive(0, 0, 1, 2'd2, 8'hAA, 8'h00, 0, 0);
    idle(3);
    chk("busy_ignored_i", 32'(reg_i[0]), 32'h12);
    drive(0, 0, 1, 2'd2, 8'h77, 8'h00, 0, 0);
    do_reset();
    idle(2);
    chk("abort_reg_i", 32'(reg_i[0]), 32'h00);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
            2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 2);
    end
    idle(4);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
